// File: rtl/sad_min_select.sv
// Minimum-SAD selector: 4-stage comparator tree over 16 lanes feeding a running-minimum
// accumulator that reports the best (sad, x, y) once per window of NUM_ROWS rows.
module sad_min_select #(
    parameter int SAD_W    = 14,
    parameter int MV_W     = 4,
    parameter int NUM_ROWS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [16*SAD_W-1:0]   sad_row,
    output logic                  busy,
    output logic                  out_valid,
    output logic [SAD_W-1:0]      sad_min,
    output logic [MV_W-1:0]       motion_vec_x_min,
    output logic [MV_W-1:0]       motion_vec_y_min
);

    localparam logic [MV_W-1:0] LAST_ROW = MV_W'(NUM_ROWS - 1);

    logic [MV_W-1:0]  row_cnt_q, row_cnt_d;
    logic             row_last, accept;

    logic [SAD_W-1:0] s1_sad_q [8], s1_sad_d [8];
    logic [MV_W-1:0]  s1_x_q   [8], s1_x_d   [8];
    logic [SAD_W-1:0] s2_sad_q [4], s2_sad_d [4];
    logic [MV_W-1:0]  s2_x_q   [4], s2_x_d   [4];
    logic [SAD_W-1:0] s3_sad_q [2], s3_sad_d [2];
    logic [MV_W-1:0]  s3_x_q   [2], s3_x_d   [2];
    logic [SAD_W-1:0] s4_sad_q, s4_sad_d;
    logic [MV_W-1:0]  s4_x_q, s4_x_d;

    logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic             s3_vld_q, s3_vld_d, s4_vld_q, s4_vld_d;
    logic [MV_W-1:0]  s1_y_q, s1_y_d, s2_y_q, s2_y_d, s3_y_q, s3_y_d, s4_y_q, s4_y_d;
    logic             s1_last_q, s1_last_d, s2_last_q, s2_last_d;
    logic             s3_last_q, s3_last_d, s4_last_q, s4_last_d;

    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [MV_W-1:0]  best_x_q, best_x_d, best_y_q, best_y_d;
    logic             acc_done_q, acc_done_d;

    logic             busy_q, busy_d, out_valid_q, out_valid_d;
    logic [SAD_W-1:0] sad_min_q, sad_min_d;
    logic [MV_W-1:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;

    // Tree: the right (higher-x) operand wins only when strictly smaller.
    always_comb begin
        row_last  = (row_cnt_q == LAST_ROW);
        accept    = in_valid && !clear;
        row_cnt_d = row_cnt_q;
        if (clear)
            row_cnt_d = '0;
        else if (in_valid)
            row_cnt_d = row_last ? '0 : row_cnt_q + MV_W'(1);

        s1_vld_d  = accept;
        s1_y_d    = row_cnt_q;
        s1_last_d = row_last;
        for (int i = 0; i < 8; i++) begin
            if (sad_row[SAD_W*(2*i+1) +: SAD_W] < sad_row[SAD_W*(2*i) +: SAD_W]) begin
                s1_sad_d[i] = sad_row[SAD_W*(2*i+1) +: SAD_W];
                s1_x_d[i]   = MV_W'(2*i+1);
            end else begin
                s1_sad_d[i] = sad_row[SAD_W*(2*i) +: SAD_W];
                s1_x_d[i]   = MV_W'(2*i);
            end
        end

        s2_vld_d  = s1_vld_q && !clear;
        s2_y_d    = s1_y_q;
        s2_last_d = s1_last_q;
        for (int i = 0; i < 4; i++) begin
            if (s1_sad_q[2*i+1] < s1_sad_q[2*i]) begin
                s2_sad_d[i] = s1_sad_q[2*i+1];
                s2_x_d[i]   = s1_x_q[2*i+1];
            end else begin
                s2_sad_d[i] = s1_sad_q[2*i];
                s2_x_d[i]   = s1_x_q[2*i];
            end
        end

        s3_vld_d  = s2_vld_q && !clear;
        s3_y_d    = s2_y_q;
        s3_last_d = s2_last_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_sad_q[2*i+1] < s2_sad_q[2*i]) begin
                s3_sad_d[i] = s2_sad_q[2*i+1];
                s3_x_d[i]   = s2_x_q[2*i+1];
            end else begin
                s3_sad_d[i] = s2_sad_q[2*i];
                s3_x_d[i]   = s2_x_q[2*i];
            end
        end

        s4_vld_d  = s3_vld_q && !clear;
        s4_y_d    = s3_y_q;
        s4_last_d = s3_last_q;
        if (s3_sad_q[1] < s3_sad_q[0]) begin
            s4_sad_d = s3_sad_q[1];
            s4_x_d   = s3_x_q[1];
        end else begin
            s4_sad_d = s3_sad_q[0];
            s4_x_d   = s3_x_q[0];
        end
    end

    // A y==0 row reseeds so consecutive windows never mix; otherwise earlier rows win ties.
    always_comb begin
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        if (s4_vld_q && !clear && (s4_y_q == '0 || s4_sad_q < best_sad_q)) begin
            best_sad_d = s4_sad_q;
            best_x_d   = s4_x_q;
            best_y_d   = s4_y_q;
        end
        acc_done_d = s4_vld_q && s4_last_q && !clear;

        out_valid_d = acc_done_q && !clear;
        sad_min_d   = sad_min_q;
        mv_x_d      = mv_x_q;
        mv_y_d      = mv_y_q;
        if (out_valid_d) begin
            sad_min_d = best_sad_q;
            mv_x_d    = best_x_q;
            mv_y_d    = best_y_q;
        end

        busy_d = busy_q;
        if (clear)
            busy_d = 1'b0;
        else if (accept && row_cnt_q == '0)
            busy_d = 1'b1;
        else if (out_valid_d)
            busy_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q   <= '0;
            s1_sad_q    <= '{default: '0};
            s1_x_q      <= '{default: '0};
            s2_sad_q    <= '{default: '0};
            s2_x_q      <= '{default: '0};
            s3_sad_q    <= '{default: '0};
            s3_x_q      <= '{default: '0};
            s4_sad_q    <= '0;
            s4_x_q      <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            s4_vld_q    <= 1'b0;
            s1_y_q      <= '0;
            s2_y_q      <= '0;
            s3_y_q      <= '0;
            s4_y_q      <= '0;
            s1_last_q   <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_last_q   <= 1'b0;
            s4_last_q   <= 1'b0;
            best_sad_q  <= '0;
            best_x_q    <= '0;
            best_y_q    <= '0;
            acc_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sad_min_q   <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            s1_sad_q    <= s1_sad_d;
            s1_x_q      <= s1_x_d;
            s2_sad_q    <= s2_sad_d;
            s2_x_q      <= s2_x_d;
            s3_sad_q    <= s3_sad_d;
            s3_x_q      <= s3_x_d;
            s4_sad_q    <= s4_sad_d;
            s4_x_q      <= s4_x_d;
            s1_vld_q    <= s1_vld_d;
            s2_vld_q    <= s2_vld_d;
            s3_vld_q    <= s3_vld_d;
            s4_vld_q    <= s4_vld_d;
            s1_y_q      <= s1_y_d;
            s2_y_q      <= s2_y_d;
            s3_y_q      <= s3_y_d;
            s4_y_q      <= s4_y_d;
            s1_last_q   <= s1_last_d;
            s2_last_q   <= s2_last_d;
            s3_last_q   <= s3_last_d;
            s4_last_q   <= s4_last_d;
            best_sad_q  <= best_sad_d;
            best_x_q    <= best_x_d;
            best_y_q    <= best_y_d;
            acc_done_q  <= acc_done_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            sad_min_q   <= sad_min_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
        end
    end

    assign busy             = busy_q;
    assign out_valid        = out_valid_q;
    assign sad_min          = sad_min_q;
    assign motion_vec_x_min = mv_x_q;
    assign motion_vec_y_min = mv_y_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: table of single-window vectors plus hand-written
// tie, back-to-back, clear and mid-search reset sequences.
module tb_sad_min_select;

    localparam int SAD_W = 14;
    localparam int MV_W  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clear = 1'b0;
    logic                in_valid = 1'b0;
    logic [16*SAD_W-1:0] sad_row = '0;
    logic                busy, out_valid;
    logic [SAD_W-1:0]    sad_min;
    logic [MV_W-1:0]     motion_vec_x_min, motion_vec_y_min;

    sad_min_select #(.SAD_W(SAD_W), .MV_W(MV_W), .NUM_ROWS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .in_valid         (in_valid),
        .sad_row          (sad_row),
        .busy             (busy),
        .out_valid        (out_valid),
        .sad_min          (sad_min),
        .motion_vec_x_min (motion_vec_x_min),
        .motion_vec_y_min (motion_vec_y_min)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every out_valid pulse is logged with its cycle number and result.
    int pv_cyc[$];
    int pv_sad[$];
    int pv_x[$];
    int pv_y[$];
    always @(negedge clk) begin
        if (out_valid) begin
            pv_cyc.push_back(cyc);
            pv_sad.push_back(int'(sad_min));
            pv_x.push_back(int'(motion_vec_x_min));
            pv_y.push_back(int'(motion_vec_y_min));
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int sp_n = 0;
    int sp_x[4];
    int sp_y[4];
    int sp_v[4];
    int last_cyc = 0;

    typedef struct {
        string name;
        int    base;
        int    sp_n;
        int    x;
        int    y;
        int    v;
        int    gap;
        int    exp_sad;
        int    exp_x;
        int    exp_y;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [16*SAD_W-1:0] build_row(input int base, input int r);
        logic [16*SAD_W-1:0] row;
        int v;
        row = '0;
        for (int lane = 0; lane < 16; lane++) begin
            v = base;
            for (int k = 0; k < sp_n; k++)
                if (sp_x[k] == lane && sp_y[k] == r) v = sp_v[k];
            row[SAD_W*lane +: SAD_W] = SAD_W'(v);
        end
        return row;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_log();
        pv_cyc.delete();
        pv_sad.delete();
        pv_x.delete();
        pv_y.delete();
    endtask

    // Leaves in_valid high after the last row so windows can run back to back.
    task automatic send_rows(input int nrows, input int base, input int gap);
        for (int r = 0; r < nrows; r++) begin
            if (gap > 0) begin
                int g;
                g = int'($urandom_range(0, gap));
                in_valid = 1'b0;
                repeat (g) step();
            end
            in_valid = 1'b1;
            sad_row  = build_row(base, r);
            step();
            last_cyc = cyc;
        end
    endtask

    function automatic int q0(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int q1(input int q[$]);
        return (q.size() > 1) ? q[1] : -1;
    endfunction

    initial begin
        vecs[0] = '{"single_min",   100,   1, 9,  5,  7,   0, 7,     9,  5};
        vecs[1] = '{"zero_origin",  100,   1, 0,  0,  0,   0, 0,     0,  0};
        vecs[2] = '{"corner_max",   1000,  1, 15, 15, 999, 0, 999,   15, 15};
        vecs[3] = '{"saturated",    16383, 0, 0,  0,  0,   0, 16383, 0,  0};
        vecs[4] = '{"gapped",       100,   1, 9,  5,  7,   3, 7,     9,  5};
        vecs[5] = '{"all_equal",    200,   1, 3,  3,  200, 0, 200,   0,  0};

        repeat (2) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sad_min", int'(sad_min), 0);
        chk("rst_mv_x", int'(motion_vec_x_min), 0);
        chk("rst_mv_y", int'(motion_vec_y_min), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            clear_log();
            sp_n    = vecs[i].sp_n;
            sp_x[0] = vecs[i].x;
            sp_y[0] = vecs[i].y;
            sp_v[0] = vecs[i].v;
            send_rows(16, vecs[i].base, vecs[i].gap);
            chk({vecs[i].name, "_busy_run"}, int'(busy), 1);
            idle(10);
            chk({vecs[i].name, "_pulses"}, pv_cyc.size(), 1);
            chk({vecs[i].name, "_latency"}, q0(pv_cyc) - last_cyc, 5);
            chk({vecs[i].name, "_sad"}, q0(pv_sad), vecs[i].exp_sad);
            chk({vecs[i].name, "_x"}, q0(pv_x), vecs[i].exp_x);
            chk({vecs[i].name, "_y"}, q0(pv_y), vecs[i].exp_y);
            chk({vecs[i].name, "_busy_done"}, int'(busy), 0);
            chk({vecs[i].name, "_hold_sad"}, int'(sad_min), vecs[i].exp_sad);
            chk({vecs[i].name, "_hold_valid"}, int'(out_valid), 0);
        end

        // Equal minima: lower x within a row, earlier row across rows.
        clear_log();
        sp_n = 3;
        sp_x[0] = 4;  sp_y[0] = 2; sp_v[0] = 3;
        sp_x[1] = 12; sp_y[1] = 2; sp_v[1] = 3;
        sp_x[2] = 1;  sp_y[2] = 7; sp_v[2] = 3;
        send_rows(16, 50, 0);
        idle(10);
        chk("tie_pulses", pv_cyc.size(), 1);
        chk("tie_sad", q0(pv_sad), 3);
        chk("tie_x", q0(pv_x), 4);
        chk("tie_y", q0(pv_y), 2);

        // Two windows with no gap between them.
        clear_log();
        sp_n = 1;
        sp_x[0] = 3; sp_y[0] = 3; sp_v[0] = 20;
        send_rows(16, 100, 0);
        sp_x[0] = 15; sp_y[0] = 15; sp_v[0] = 9;
        send_rows(16, 100, 0);
        idle(10);
        chk("b2b_pulses", pv_cyc.size(), 2);
        chk("b2b_spacing", q1(pv_cyc) - q0(pv_cyc), 16);
        chk("b2b_b_latency", q1(pv_cyc) - last_cyc, 5);
        chk("b2b_a_sad", q0(pv_sad), 20);
        chk("b2b_a_x", q0(pv_x), 3);
        chk("b2b_a_y", q0(pv_y), 3);
        chk("b2b_b_sad", q1(pv_sad), 9);
        chk("b2b_b_x", q1(pv_x), 15);
        chk("b2b_b_y", q1(pv_y), 15);

        // Abort after 8 rows with clear; the ignored clear-cycle row is all zeros.
        clear_log();
        sp_n = 1;
        sp_x[0] = 0; sp_y[0] = 3; sp_v[0] = 0;
        send_rows(8, 100, 0);
        chk("clr_busy_before", int'(busy), 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        sad_row  = '0;
        step();
        clear    = 1'b0;
        chk("clr_busy_after", int'(busy), 0);
        chk("clr_sad_kept", int'(sad_min), 9);
        idle(12);
        chk("clr_no_pulse", pv_cyc.size(), 0);
        sp_x[0] = 6; sp_y[0] = 10; sp_v[0] = 1;
        send_rows(16, 100, 0);
        idle(10);
        chk("clr_pulses", pv_cyc.size(), 1);
        chk("clr_sad", q0(pv_sad), 1);
        chk("clr_x", q0(pv_x), 6);
        chk("clr_y", q0(pv_y), 10);

        // Abort after 8 rows with reset.
        clear_log();
        sp_x[0] = 2; sp_y[0] = 1; sp_v[0] = 0;
        send_rows(8, 100, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_sad", int'(sad_min), 0);
        chk("rst_mid_x", int'(motion_vec_x_min), 0);
        rst = 1'b0;
        step();
        sp_x[0] = 6; sp_y[0] = 10; sp_v[0] = 1;
        send_rows(16, 100, 0);
        chk("rst_pre_pulse_sad", int'(sad_min), 0);
        idle(10);
        chk("rst_pulses", pv_cyc.size(), 1);
        chk("rst_sad", q0(pv_sad), 1);
        chk("rst_x", q0(pv_x), 6);
        chk("rst_y", q0(pv_y), 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
